// File: rtl/cache_pkg.sv
// Shared cache constants, types and tree-PLRU helper functions for the L1 tag lookup.
package cache_pkg;

    localparam int unsigned DEF_WAYS  = 4;
    localparam int unsigned DEF_TAG_W = 23;
    localparam int unsigned DEF_SETS  = 16;

    // Helpers work on a wide vector so any power-of-two way count up to 64 can use them.
    localparam int unsigned PLRU_MAX_LEVELS = 6;

    typedef logic [$clog2(DEF_WAYS)-1:0] way_idx_t;
    typedef logic [$clog2(DEF_SETS)-1:0] set_idx_t;
    typedef logic [DEF_TAG_W-1:0]        tag_t;
    typedef logic [DEF_WAYS-2:0]         plru_bits_t;
    typedef logic [63:0]                 plru_vec_t;

    // Walk from the root; a node bit of 0 steers toward the left child.
    function automatic int unsigned plru_victim(input plru_vec_t bits, input int unsigned levels);
        int unsigned node;
        node = 0;
        for (int unsigned l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < levels) begin
                node = bits[node[5:0]] ? 2 * node + 2 : 2 * node + 1;
            end
        end
        return node - ((32'd1 << levels) - 1);
    endfunction

    function automatic plru_vec_t plru_touch(input plru_vec_t bits, input int unsigned way,
                                             input int unsigned levels);
        plru_vec_t   res;
        int unsigned node;
        int unsigned sh;
        logic        dir;
        res  = bits;
        node = 0;
        for (int unsigned l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < levels) begin
                sh  = levels - 1 - l;
                dir = way[sh[4:0]];
                res[node[5:0]] = !dir;
                node = dir ? 2 * node + 2 : 2 * node + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// One set's tree-PLRU: combinational victim and next state after making touch_way MRU.
module plru_tree
    import cache_pkg::*;
#(
    parameter  int unsigned WAYS  = DEF_WAYS,
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  bits,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim,
    output logic [WAYS-2:0]  bits_next
);

    plru_vec_t cur_vec;
    plru_vec_t next_vec;
    logic      unused_next_hi;

    always_comb begin
        cur_vec             = '0;
        cur_vec[WAYS-2:0]   = bits;
        victim              = WAY_W'(plru_victim(cur_vec, WAY_W));
        next_vec            = plru_touch(cur_vec, 32'(touch_way), WAY_W);
        bits_next           = next_vec[WAYS-2:0];
    end

    assign unused_next_hi = ^next_vec[63:WAYS-1];

endmodule

// File: rtl/tag_lookup_plru.sv
// N-way tag lookup with registered hit/way/victim and per-set tree-PLRU state.
// Optional sticky multi-hit detection is enabled by defining MULTIHIT_CHECK_EN.
module tag_lookup_plru
    import cache_pkg::*;
#(
    parameter  int unsigned WAYS  = DEF_WAYS,
    parameter  int unsigned TAG_W = DEF_TAG_W,
    parameter  int unsigned SETS  = DEF_SETS,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [IDX_W-1:0]      req_set,
    input  logic [WAYS*TAG_W-1:0] way_tags,
    input  logic [WAYS-1:0]       way_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [WAY_W-1:0]      rsp_way,
    output logic [WAY_W-1:0]      rsp_victim,
    input  logic                  fill_valid,
    input  logic [IDX_W-1:0]      fill_set,
    input  logic [WAY_W-1:0]      fill_way,
    output logic                  err_multihit
);

    logic [WAYS-2:0]  plru_q [SETS];
    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic [WAY_W-1:0] rsp_way_q;
    logic [WAY_W-1:0] rsp_victim_q;

    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic             all_valid;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] plru_way;
    logic [WAY_W-1:0] victim_way;
    logic             accept;
    logic             hit_upd;
    logic [WAYS-2:0]  hit_bits_next;
    logic [WAYS-2:0]  fill_bits_cur;
    logic [WAYS-2:0]  fill_bits_next;
    logic [WAY_W-1:0] unused_fill_victim;

    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        free_way = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            hit_vec[i] = way_valid[i] && (way_tags[i*TAG_W +: TAG_W] == req_tag);
        end
        // Descending scan so the lowest matching / lowest invalid index is left standing.
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WAY_W'(i);
            if (!way_valid[i]) free_way = WAY_W'(i);
        end
    end

    assign hit_any    = |hit_vec;
    assign all_valid  = &way_valid;
    assign victim_way = all_valid ? plru_way : free_way;
    assign req_ready  = !rsp_valid_q || rsp_ready;
    assign accept     = req_valid && req_ready;
    assign hit_upd    = accept && hit_any;

    plru_tree #(.WAYS(WAYS)) u_hit_tree (
        .bits      (plru_q[req_set]),
        .touch_way (hit_way),
        .victim    (plru_way),
        .bits_next (hit_bits_next)
    );

    // Chaining the fill onto the hit result makes the fill win on shared nodes.
    assign fill_bits_cur = (hit_upd && (fill_set == req_set)) ? hit_bits_next : plru_q[fill_set];

    plru_tree #(.WAYS(WAYS)) u_fill_tree (
        .bits      (fill_bits_cur),
        .touch_way (fill_way),
        .victim    (unused_fill_victim),
        .bits_next (fill_bits_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_victim_q <= '0;
            for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
        end else begin
            if (accept) begin
                rsp_valid_q  <= 1'b1;
                rsp_hit_q    <= hit_any;
                rsp_way_q    <= hit_any ? hit_way : '0;
                rsp_victim_q <= victim_way;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (hit_upd) plru_q[req_set] <= hit_bits_next;
            if (fill_valid) plru_q[fill_set] <= fill_bits_next;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_way    = rsp_way_q;
    assign rsp_victim = rsp_victim_q;

`ifdef MULTIHIT_CHECK_EN
    logic multihit;
    logic err_multihit_q;

    assign multihit = |(hit_vec & (hit_vec - WAYS'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_multihit_q <= 1'b0;
        end else if (accept && multihit) begin
            err_multihit_q <= 1'b1;
        end
    end

    assign err_multihit = err_multihit_q;
`else
    assign err_multihit = 1'b0;
`endif

endmodule
